// File: rtl/prewish5k_pkg.sv
// Shared definitions for the DIP-load front end: FSM encoding, defaults,
// debug view and the mask helper.
package prewish5k_pkg;

  localparam int DEB_BITS_DEFAULT   = 16;
  localparam int ALIVE_BITS_DEFAULT = 23;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'b00,
    RESEND_GAP   = 2'b01,
    WAIT_PRESS   = 2'b10,
    STROBE       = 2'b11
  } state_t;

  // Debug view of the controller, exported so checkers can bind to it.
  typedef struct packed {
    state_t state;
    logic   resend;
    logic   btn_idle;
    logic   dip_idle;
  } dbg_t;

  // DIP switches are active low; the blink mask is active high.
  function automatic logic [7:0] mask_from_dip(input logic [7:0] dip);
    return ~dip;
  endfunction

endpackage

// File: rtl/prewish5k_sync_debounce.sv
// Two-flop synchroniser followed by a shared-counter debouncer for a
// WIDTH-bit vector. The whole vector is accepted at once after it has
// been stable, and different from the accepted value, for a full window.
module prewish5k_sync_debounce #(
  parameter int               WIDTH    = 1,
  parameter int               DEB_BITS = 16,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_deb,
  output logic             o_idle
);

  logic [WIDTH-1:0]    meta_q;
  logic [WIDTH-1:0]    sync_q;
  logic [WIDTH-1:0]    prev_q;
  logic [WIDTH-1:0]    deb_q;
  logic [DEB_BITS-1:0] cnt_q;

  localparam logic [DEB_BITS-1:0] CNT_ONE = {{(DEB_BITS-1){1'b0}}, 1'b1};

  // Bring the raw asynchronous inputs into the clock domain; prev_q lets
  // the debouncer notice the vector moving while a count is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= i_raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Count consecutive cycles of a stable, new value; accept at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= RST_VAL;
      cnt_q <= '0;
    end else if ((sync_q == deb_q) || (sync_q != prev_q)) begin
      cnt_q <= '0;
    end else if (cnt_q == '1) begin
      deb_q <= sync_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign o_deb  = deb_q;
  assign o_idle = (sync_q == deb_q);

endmodule

// File: rtl/prewish5k_dipload.sv
// Front-end input stage: debounces the button and DIP switches and loads
// the inverted DIP value as the blink mask on each clean button press.
//
// Handshake: STB_O is high for exactly one cycle whenever DAT_O carries a
// mask for the consumer, and is never high on two consecutive cycles.
// STB_I is a one-cycle resend request, honoured only while waiting for a
// press; at any other time it is dropped. DAT_O changes only on the edge
// that raises STB_O for a press, and is otherwise stable.
module prewish5k_dipload
  import prewish5k_pkg::*;
#(
  parameter int DEB_BITS   = DEB_BITS_DEFAULT,
  parameter int ALIVE_BITS = ALIVE_BITS_DEFAULT
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_button,
  input  logic [7:0] i_dip,
  input  logic       STB_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic       o_alive,
  output dbg_t       o_dbg
);

  logic                  btn_deb;
  logic                  btn_idle;
  logic [7:0]            dip_deb;
  logic                  dip_idle;
  state_t                state_q;
  state_t                state_d;
  logic                  resend_q;
  logic                  load_mask;
  logic                  take_resend;
  logic [1:0]            primed_q;
  logic [ALIVE_BITS-1:0] alive_q;

  prewish5k_sync_debounce #(
    .WIDTH    (1),
    .DEB_BITS (DEB_BITS),
    .RST_VAL  (1'b0)
  ) u_btn (
    .clk    (CLK_I),
    .rst_n  (RST_I),
    .i_raw  (i_button),
    .o_deb  (btn_deb),
    .o_idle (btn_idle)
  );

  prewish5k_sync_debounce #(
    .WIDTH    (8),
    .DEB_BITS (DEB_BITS),
    .RST_VAL  (8'hFF)
  ) u_dip (
    .clk    (CLK_I),
    .rst_n  (RST_I),
    .i_raw  (i_dip),
    .o_deb  (dip_deb),
    .o_idle (dip_idle)
  );

  // Hold off the release check until the synchroniser has filled, so a
  // button held through reset is not mistaken for a released one.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      primed_q <= 2'd0;
    end else if (!primed_q[1]) begin
      primed_q <= primed_q + 2'd1;
    end
  end

  // State register; resend_q remembers whether the pulse now being sent
  // was a resend, which decides where STROBE goes next.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q  <= WAIT_RELEASE;
      resend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resend_q <= take_resend;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_RELEASE: if (primed_q[1] && !btn_deb && btn_idle) state_d = WAIT_PRESS;
      WAIT_PRESS:   if (btn_deb || STB_I) state_d = STROBE;
      STROBE:       state_d = resend_q ? RESEND_GAP : WAIT_RELEASE;
      RESEND_GAP:   state_d = WAIT_PRESS;
      default:      state_d = WAIT_RELEASE;
    endcase
  end

  // Output decode: a press beats a simultaneous resend request.
  always_comb begin
    STB_O       = (state_q == STROBE);
    load_mask   = (state_q == WAIT_PRESS) && btn_deb;
    take_resend = (state_q == WAIT_PRESS) && !btn_deb && STB_I;
  end

  // Mask register, loaded only on the press edge.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      DAT_O <= 8'h00;
    end else if (load_mask) begin
      DAT_O <= mask_from_dip(dip_deb);
    end
  end

  // Free-running alive counter; its MSB blinks the indicator.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      alive_q <= '0;
    end else begin
      alive_q <= alive_q + {{(ALIVE_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign o_alive = alive_q[ALIVE_BITS-1];
  assign o_dbg   = '{state: state_q, resend: resend_q, btn_idle: btn_idle, dip_idle: dip_idle};

endmodule

// File: tb/tb_prewish5k_dipload.sv
// Bench for prewish5k_dipload with short debounce and alive counters.
module tb_prewish5k_dipload;
  import prewish5k_pkg::*;

  localparam int DEB = 4;
  localparam int ALV = 4;
  localparam int WIN = (1 << DEB) + 1;  // stable synchronised cycles to accept

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b0;
  logic       i_button = 1'b0;
  logic [7:0] i_dip = 8'h00;
  logic       STB_I = 1'b0;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic       o_alive;
  dbg_t       dbg;

  prewish5k_dipload #(.DEB_BITS(DEB), .ALIVE_BITS(ALV)) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .i_button (i_button),
    .i_dip    (i_dip),
    .STB_I    (STB_I),
    .STB_O    (STB_O),
    .DAT_O    (DAT_O),
    .o_alive  (o_alive),
    .o_dbg    (dbg)
  );

  // clock / reset
  always #5 CLK_I = ~CLK_I;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];

  // Reference model: synchroniser as a 2-deep delay, debounce as run
  // length of the synchronised value, controller as arm/cooldown rules.
  logic       m_b1, m_b2, m_blast, m_bdeb;
  logic [7:0] m_d1, m_d2, m_dlast, m_ddeb;
  int         m_brun, m_drun;
  int         m_hold, m_n;
  bit         m_armed, m_stb;
  logic [7:0] m_dat;

  task automatic model_reset();
    m_b1 = 1'b0; m_b2 = 1'b0; m_blast = 1'b0; m_bdeb = 1'b0; m_brun = 0;
    m_d1 = 8'hFF; m_d2 = 8'hFF; m_dlast = 8'hFF; m_ddeb = 8'hFF; m_drun = 0;
    m_hold = 0; m_n = 0; m_armed = 0; m_stb = 0; m_dat = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_edge();
    m_n++;
    m_stb = 0;
    if (m_hold > 0) m_hold--;
    else if (!m_armed) begin
      if (m_n >= 3 && !m_bdeb && !m_b2) m_armed = 1;
    end else if (m_bdeb) begin
      m_dat = ~m_ddeb; m_stb = 1; m_armed = 0; m_hold = 1;
      exp_q.push_back(m_dat);
    end else if (STB_I) begin
      m_stb = 1; m_hold = 2;
      exp_q.push_back(m_dat);
    end
    if (m_b2 == m_blast) m_brun = (m_brun < 1000) ? m_brun + 1 : m_brun; else m_brun = 1;
    m_blast = m_b2;
    if (m_brun >= WIN && m_b2 != m_bdeb) m_bdeb = m_b2;
    if (m_d2 == m_dlast) m_drun = (m_drun < 1000) ? m_drun + 1 : m_drun; else m_drun = 1;
    m_dlast = m_d2;
    if (m_drun >= WIN && m_d2 != m_ddeb) m_ddeb = m_d2;
    m_b2 = m_b1; m_b1 = i_button;
    m_d2 = m_d1; m_d1 = i_dip;
  endtask

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model on the rising edge, compare on the falling edge.
  task automatic step();
    logic exp_alive;
    @(posedge CLK_I);
    if (RST_I) model_edge();
    @(negedge CLK_I);
    if (STB_O === 1'b1) pulses++;
    if (!RST_I) begin
      check_val("in_reset", {6'd0, STB_O, o_alive} | {DAT_O != 8'h00, 7'd0}, 8'h00);
    end else begin
      exp_alive = ((m_n % (1 << ALV)) >= (1 << (ALV - 1)));
      check_val("stb_o", {7'd0, STB_O}, {7'd0, m_stb});
      check_val("dat_o", DAT_O, m_dat);
      check_val("alive", {7'd0, o_alive}, {7'd0, exp_alive});
      if (STB_O === 1'b1) begin
        if (exp_q.size() == 0) check_val("unexpected_pulse", DAT_O, 8'hxx);
        else check_val("pulse_mask", DAT_O, exp_q.pop_front());
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input logic btn, input logic [7:0] dip);
    i_button = btn; i_dip = dip; STB_I = 1'b0;
    RST_I = 1'b0;
    model_reset();
    steps(3);
    RST_I = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic       btn;
    logic [7:0] dip;
    int         cycles;
    int         exp_pulses;
    logic [7:0] exp_dat;
  } phase_t;

  phase_t tbl[7];
  int     guard;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00, 30, 0, 8'h00};  // reset, idle
    tbl[1] = '{1'b0, 1'b1, 8'h00, 10, 0, 8'h00};  // short glitch
    tbl[2] = '{1'b0, 1'b0, 8'h00, 25, 0, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'hA5, 30, 0, 8'h00};  // button held through reset
    tbl[4] = '{1'b0, 1'b0, 8'hA5, 25, 0, 8'h00};  // release
    tbl[5] = '{1'b0, 1'b1, 8'hA5, 25, 1, 8'h5A};  // press loads ~A5
    tbl[6] = '{1'b0, 1'b0, 8'hA5, 25, 0, 8'h5A};

    @(negedge CLK_I);
    for (int t = 0; t < 7; t++) begin
      if (tbl[t].rst) do_reset(tbl[t].btn, tbl[t].dip);
      i_button = tbl[t].btn; i_dip = tbl[t].dip;
      pulses = 0;
      steps(tbl[t].cycles);
      check_val($sformatf("row%0d_pulses", t), 8'(pulses), 8'(tbl[t].exp_pulses));
      check_val($sformatf("row%0d_dat", t), DAT_O, tbl[t].exp_dat);
    end

    // Resend one cycle after STB_I; a second request the next cycle is dropped.
    pulses = 0;
    STB_I = 1'b1;
    step();
    check_val("resend_latency", {7'd0, STB_O}, 8'h01);
    step();
    STB_I = 1'b0;
    steps(10);
    check_val("resend_pulses", 8'(pulses), 8'd1);
    check_val("resend_dat", DAT_O, 8'h5A);

    // STB_I on the very edge the press is accepted: one pulse, new mask.
    i_dip = 8'hF0;
    steps(25);
    i_button = 1'b1;
    pulses = 0;
    guard = 0;
    while (!m_bdeb && guard < 40) begin step(); guard++; end
    check_val("press_seen", {7'd0, m_bdeb}, 8'h01);
    STB_I = 1'b1;
    step();
    STB_I = 1'b0;
    steps(10);
    check_val("coincident_pulses", 8'(pulses), 8'd1);
    check_val("coincident_dat", DAT_O, 8'h0F);

    // DIP moves shortly before the press is accepted: old value is loaded.
    i_button = 1'b0; i_dip = 8'hFF;
    steps(25);
    pulses = 0;
    i_button = 1'b1;
    steps(13);
    i_dip = 8'h00;
    steps(15);
    check_val("late_dip_pulses", 8'(pulses), 8'd1);
    check_val("late_dip_dat", DAT_O, 8'h00);
    i_button = 1'b0;
    steps(25);
    pulses = 0;
    i_button = 1'b1;
    steps(25);
    check_val("next_press_pulses", 8'(pulses), 8'd1);
    check_val("next_press_dat", DAT_O, 8'hFF);

    // Asynchronous reset while STB_O is high.
    i_button = 1'b0; i_dip = 8'h3C;
    steps(25);
    i_button = 1'b1;
    guard = 0;
    while (STB_O !== 1'b1 && guard < 40) begin step(); guard++; end
    check_val("pulse_before_reset", {7'd0, STB_O}, 8'h01);
    #1 RST_I = 1'b0;
    model_reset();
    #1;
    check_val("async_stb", {7'd0, STB_O}, 8'h00);
    check_val("async_dat", DAT_O, 8'h00);
    steps(2);
    RST_I = 1'b1;
    steps(7);
    check_val("alive_low", {7'd0, o_alive}, 8'h00);
    step();
    check_val("alive_high", {7'd0, o_alive}, 8'h01);
    steps(8);
    check_val("alive_wrap", {7'd0, o_alive}, 8'h00);

    // Random phases against the model.
    do_reset(1'b0, 8'($urandom));
    for (int p = 0; p < 40; p++) begin
      i_button = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) i_dip = 8'($urandom);
      for (int c = 0, n = int'($urandom_range(1, 30)); c < n; c++) begin
        STB_I = ($urandom_range(0, 9) == 0);
        step();
      end
    end
    STB_I = 1'b0;
    steps(5);
    check_val("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
